// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: op codes, operand-B selects,
// FSM state type, the per-requester request bundle and latency helpers.
// Pure definitions; no timing or flow control lives here.
package alu_ctrl_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_MULH = 4'b0011;
    localparam logic [3:0] OP_DIV  = 4'b0100;
    localparam logic [3:0] OP_REM  = 4'b0101;
    localparam logic [3:0] OP_AND  = 4'b0110;
    localparam logic [3:0] OP_OR   = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b1001;
    localparam logic [3:0] OP_SRL  = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1011;
    localparam logic [3:0] OP_SLT  = 4'b1100;
    localparam logic [3:0] OP_SLTU = 4'b1101;
    localparam logic [3:0] OP_EQ   = 4'b1110;

    // Operand-B select; bit 1 set means rs2 regardless of bit 0.
    localparam logic [1:0] IRMUX_IMMS = 2'b00;
    localparam logic [1:0] IRMUX_IMMI = 2'b01;
    localparam logic [1:0] IRMUX_RS2  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [1:0]  irmux;
        logic [31:0] a;
        logic [31:0] rs2;
        logic [31:0] imm_s;
        logic [31:0] imm_i;
    } req_t;

    function automatic int op_latency(input logic [3:0] op, input int mul_cycles,
                                      input int div_cycles);
        case (op)
            OP_MUL, OP_MULH: return mul_cycles;
            OP_DIV, OP_REM:  return div_cycles;
            default:         return 1;
        endcase
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    // The operand the ALU will actually use as B.
    function automatic logic [31:0] eff_b(input req_t r);
        if (r.irmux[1])
            return r.rs2;
        else if (r.irmux[0])
            return r.imm_i;
        else
            return r.imm_s;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; one-hot grant among valid requesters when enabled.
// Latency: grant is combinational; last_grant updates on the granted edge.
// Backpressure: no grant while en is low; a lone requester always wins.
// Ports: clk/rst_n, en (controller can accept), req_valid[1:0], grant[1:0], gnt_id.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req_valid,
    output logic [1:0] grant,
    output logic       gnt_id
);

    logic last_grant;

    always_comb begin
        // On contention favour whoever did not win last time.
        gnt_id = (&req_valid) ? ~last_grant : req_valid[1];
        grant  = 2'b00;
        if (en && (|req_valid))
            grant = gnt_id ? 2'b10 : 2'b01;
    end

    // Reset to 1 so requester 0 wins the first contended cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_grant <= 1'b1;
        else if (|grant)
            last_grant <= gnt_id;
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue sequencer for the shared ALU: arbitrates two requesters, holds operands for the op's latency, returns a tagged result.
// Latency: result valid L edges after accept (L = MUL_CYCLES / DIV_CYCLES / 1); issue-to-issue >= L+2 cycles.
// Backpressure: req_ready only in IDLE; result held in RESP until rsp_ready, no new accept meanwhile.
// Ports: req_* (two packed requesters), alu_* (registered operands / returned result), rsp_* (tagged response), busy.
module alu_issue_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [7:0]  req_op,
    input  logic [3:0]  req_irmux,
    input  logic [63:0] req_a,
    input  logic [63:0] req_rs2,
    input  logic [63:0] req_imm_s,
    input  logic [63:0] req_imm_i,
    output logic [31:0] alu_a,
    output logic [31:0] alu_rs2,
    output logic [31:0] alu_imm_s,
    output logic [31:0] alu_imm_i,
    output logic [1:0]  alu_irmux,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_out,
    input  logic        alu_bt,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic        rsp_bt,
    output logic        busy
);

    localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    // cnt only ever holds L-1, so it needs to reach MAX_LAT-1.
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             div_zero;

    logic             arb_en;
    logic [1:0]       grant;
    logic             gnt_id;

    req_t             req0;
    req_t             req1;
    req_t             sel;
    logic             sel_div_zero;
    int               sel_lat;
    logic [31:0]      ovr_data;

    assign req0 = '{op: req_op[3:0], irmux: req_irmux[1:0], a: req_a[31:0],
                    rs2: req_rs2[31:0], imm_s: req_imm_s[31:0], imm_i: req_imm_i[31:0]};
    assign req1 = '{op: req_op[7:4], irmux: req_irmux[3:2], a: req_a[63:32],
                    rs2: req_rs2[63:32], imm_s: req_imm_s[63:32], imm_i: req_imm_i[63:32]};

    assign arb_en = (state == IDLE);

    rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (arb_en),
        .req_valid (req_valid),
        .grant     (grant),
        .gnt_id    (gnt_id)
    );

    assign req_ready = grant;
    assign busy      = (state != IDLE);

    always_comb begin
        sel          = gnt_id ? req1 : req0;
        // A zero divisor bypasses the divider entirely, so it completes in one cycle.
        sel_div_zero = is_div(sel.op) && (eff_b(sel) == 32'd0);
        sel_lat      = sel_div_zero ? 1 : op_latency(sel.op, MUL_CYCLES, DIV_CYCLES);
    end

    // Divide-by-zero result: all-ones quotient, remainder equals the dividend.
    assign ovr_data = (alu_op == OP_DIV) ? 32'hFFFF_FFFF : alu_a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            div_zero  <= 1'b0;
            alu_a     <= '0;
            alu_rs2   <= '0;
            alu_imm_s <= '0;
            alu_imm_i <= '0;
            alu_irmux <= '0;
            alu_op    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_bt    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        alu_op    <= sel.op;
                        alu_irmux <= sel.irmux;
                        alu_a     <= sel.a;
                        alu_rs2   <= sel.rs2;
                        alu_imm_s <= sel.imm_s;
                        alu_imm_i <= sel.imm_i;
                        rsp_id    <= gnt_id;
                        div_zero  <= sel_div_zero;
                        cnt       <= CNT_W'(sel_lat - 1);
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    // alu_* are frozen here; this is what makes the multicycle path legal.
                    if (cnt == '0) begin
                        if (div_zero) begin
                            rsp_data <= ovr_data;
                            rsp_bt   <= ovr_data[0];
                        end else begin
                            rsp_data <= alu_out;
                            rsp_bt   <= alu_bt;
                        end
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;
    import alu_ctrl_pkg::*;

    localparam int MULC = 4;
    localparam int DIVC = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [7:0]  req_op = '0;
    logic [3:0]  req_irmux = '0;
    logic [63:0] req_a = '0, req_rs2 = '0, req_imm_s = '0, req_imm_i = '0;
    logic [31:0] alu_a, alu_rs2, alu_imm_s, alu_imm_i;
    logic [1:0]  alu_irmux;
    logic [3:0]  alu_op;
    logic [31:0] alu_out;
    logic        alu_bt;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        rsp_id;
    logic [31:0] rsp_data;
    logic        rsp_bt;
    logic        busy;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_irmux(req_irmux),
        .req_a(req_a), .req_rs2(req_rs2), .req_imm_s(req_imm_s), .req_imm_i(req_imm_i),
        .alu_a(alu_a), .alu_rs2(alu_rs2), .alu_imm_s(alu_imm_s), .alu_imm_i(alu_imm_i),
        .alu_irmux(alu_irmux), .alu_op(alu_op), .alu_out(alu_out), .alu_bt(alu_bt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_bt(rsp_bt), .busy(busy)
    );

    // ---------------- ALU environment model ----------------
    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] p;
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_MUL:  return a * b;
            OP_MULH: begin
                p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return p[63:32];
            end
            OP_DIV:  return (b == 0) ? 32'h0BAD_0BAD : a / b;
            OP_REM:  return (b == 0) ? 32'h0BAD_0BAD : a % b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLL:  return a << b[4:0];
            OP_SRL:  return a >> b[4:0];
            OP_SRA:  return $signed(a) >>> b[4:0];
            OP_SLT:  return {31'd0, $signed(a) < $signed(b)};
            OP_SLTU: return {31'd0, a < b};
            OP_EQ:   return {31'd0, a == b};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] pick_b(input logic [1:0] irm, input logic [31:0] rs2,
                                           input logic [31:0] imms, input logic [31:0] immi);
        if (irm == IRMUX_RS2 || irm == 2'b11) return rs2;
        if (irm == IRMUX_IMMI) return immi;
        return imms;
    endfunction

    always_comb begin
        alu_out = alu_ref(alu_op, alu_a, pick_b(alu_irmux, alu_rs2, alu_imm_s, alu_imm_i));
        alu_bt  = (alu_out == 32'd0);
    end

    // ---------------- checking helper ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    bit          m_idle, m_rspv, m_last, m_id, m_bt, m_pbt;
    logic [3:0]  m_op;
    logic [1:0]  m_irmux;
    logic [31:0] m_a, m_rs2, m_imms, m_immi, m_data, m_pdata, m_b;
    int          ecount, m_rsp_at, m_lat, m_k;
    logic [1:0]  m_g;

    function automatic logic [1:0] exp_ready(input logic [1:0] v, input bit idle, input bit last);
        if (!idle || v == 2'b00) return 2'b00;
        if (v == 2'b11) return last ? 2'b01 : 2'b10;
        return v;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_idle = 1; m_rspv = 0; m_last = 1; m_id = 0; m_bt = 0; m_pbt = 0;
                m_op = 0; m_irmux = 0; m_a = 0; m_rs2 = 0; m_imms = 0; m_immi = 0;
                m_data = 0; m_pdata = 0; ecount = 0; m_rsp_at = 0;
            end else begin
                ecount++;
                if (m_idle) begin
                    m_g = exp_ready(req_valid, 1'b1, m_last);
                    if (m_g != 2'b00) begin
                        m_k     = m_g[1] ? 1 : 0;
                        m_op    = req_op[4*m_k +: 4];
                        m_irmux = req_irmux[2*m_k +: 2];
                        m_a     = req_a[32*m_k +: 32];
                        m_rs2   = req_rs2[32*m_k +: 32];
                        m_imms  = req_imm_s[32*m_k +: 32];
                        m_immi  = req_imm_i[32*m_k +: 32];
                        m_id    = m_g[1];
                        m_last  = m_g[1];
                        m_b     = pick_b(m_irmux, m_rs2, m_imms, m_immi);
                        if ((m_op == 4'b0100 || m_op == 4'b0101) && m_b == 0) begin
                            m_lat   = 1;
                            m_pdata = (m_op == 4'b0100) ? 32'hFFFF_FFFF : m_a;
                            m_pbt   = m_pdata[0];
                        end else begin
                            if (m_op == 4'b0010 || m_op == 4'b0011) m_lat = MULC;
                            else if (m_op == 4'b0100 || m_op == 4'b0101) m_lat = DIVC;
                            else m_lat = 1;
                            m_pdata = alu_ref(m_op, m_a, m_b);
                            m_pbt   = (m_pdata == 0);
                        end
                        m_rsp_at = ecount + m_lat;
                        m_idle   = 0;
                    end
                end else if (!m_rspv) begin
                    if (ecount == m_rsp_at) begin
                        m_rspv = 1; m_data = m_pdata; m_bt = m_pbt;
                    end
                end else if (rsp_ready) begin
                    m_rspv = 0; m_idle = 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && chk_en) begin
                chk("req_ready", 64'(req_ready), 64'(exp_ready(req_valid, m_idle, m_last)));
                chk("busy", 64'(busy), 64'(!m_idle));
                chk("rsp_valid", 64'(rsp_valid), 64'(m_rspv));
                chk("rsp_fields", 64'({rsp_id, rsp_bt, rsp_data}), 64'({m_id, m_bt, m_data}));
                chk("alu_op_irmux", 64'({alu_op, alu_irmux}), 64'({m_op, m_irmux}));
                chk("alu_a_rs2", {alu_a, alu_rs2}, {m_a, m_rs2});
                chk("alu_imms_immi", {alu_imm_s, alu_imm_i}, {m_imms, m_immi});
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic set_req(input int i, input logic [3:0] op, input logic [1:0] irm,
                           input logic [31:0] a, input logic [31:0] rs2,
                           input logic [31:0] imms, input logic [31:0] immi);
        req_op[4*i +: 4]      = op;
        req_irmux[2*i +: 2]   = irm;
        req_a[32*i +: 32]     = a;
        req_rs2[32*i +: 32]   = rs2;
        req_imm_s[32*i +: 32] = imms;
        req_imm_i[32*i +: 32] = immi;
    endtask

    task automatic issue(input int i, input logic [3:0] op, input logic [1:0] irm,
                         input logic [31:0] a, input logic [31:0] rs2,
                         input logic [31:0] imms, input logic [31:0] immi);
        bit got = 0;
        set_req(i, op, irm, a, rs2, imms, immi);
        req_valid[i] = 1'b1;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (req_ready[i]) got = 1;
            @(posedge clk); #1;
        end
        req_valid[i] = 1'b0;
        if (!got) chk("accept_timeout", 64'(0), 64'(1));
    endtask

    // Edges from accept until rsp_valid; returns just after the following edge.
    task automatic wait_rsp(output int n, output logic [31:0] d, output logic id);
        bit got = 0;
        n = 0; d = '0; id = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1; d = rsp_data; id = rsp_id;
            end else begin
                @(posedge clk); #1;
                n++;
            end
        end
        if (!got) chk("rsp_timeout", 64'(0), 64'(1));
        @(posedge clk); #1;
    endtask

    int          n;
    logic [31:0] d;
    logic        id;
    int          ng, nr, prev_v;
    int          gseq[4];
    int          acc_k[4];
    int          lat[4];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1;
        chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_alu_op", 64'(alu_op), 64'(0));
        chk("reset_rsp_data", 64'(rsp_data), 64'(0));
        chk("reset_req_ready", 64'(req_ready), 64'(0));
        @(posedge clk); @(posedge clk); #3;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;

        // ADD a=5 rs2=7 from requester 0
        issue(0, OP_ADD, IRMUX_RS2, 32'd5, 32'd7, 32'd0, 32'd0);
        wait_rsp(n, d, id);
        chk("add_latency", 64'(n), 64'(1));
        chk("add_data", 64'(d), 64'(12));
        chk("add_id", 64'(id), 64'(0));

        // Both requesters valid continuously: req1 MUL, req0 XOR
        set_req(1, OP_MUL, IRMUX_RS2, 32'd6, 32'd7, 32'd0, 32'd0);
        set_req(0, OP_XOR, IRMUX_IMMS, 32'h0000_F0F0, 32'd0, 32'h0000_0FF0, 32'd0);
        req_valid = 2'b11;
        ng = 0; nr = 0; prev_v = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (req_ready != 2'b00 && ng < 4) begin
                gseq[ng] = req_ready[1] ? 1 : 0;
                acc_k[ng] = k;
                ng++;
            end
            if (rsp_valid && prev_v == 0 && nr < 4) begin
                lat[nr] = k - acc_k[nr] - 1;
                nr++;
            end
            prev_v = rsp_valid ? 1 : 0;
            if (ng >= 4 && nr >= 4 && req_ready == 2'b00) begin
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        chk("rr_grant0", 64'(gseq[0]), 64'(1));
        chk("rr_grant1", 64'(gseq[1]), 64'(0));
        chk("rr_grant2", 64'(gseq[2]), 64'(1));
        chk("rr_grant3", 64'(gseq[3]), 64'(0));
        chk("mul_latency", 64'(lat[0]), 64'(4));
        chk("xor_latency", 64'(lat[1]), 64'(1));

        // Divide by zero via imm_i, then remainder by zero, then a real divide
        issue(1, OP_DIV, IRMUX_IMMI, 32'd100, 32'd55, 32'd9, 32'd0);
        wait_rsp(n, d, id);
        chk("divz_latency", 64'(n), 64'(1));
        chk("divz_data", 64'(d), 64'hFFFF_FFFF);
        chk("divz_id", 64'(id), 64'(1));
        issue(1, OP_REM, IRMUX_IMMI, 32'd100, 32'd55, 32'd9, 32'd0);
        wait_rsp(n, d, id);
        chk("remz_data", 64'(d), 64'(100));
        issue(0, OP_DIV, IRMUX_RS2, 32'd100, 32'd7, 32'd0, 32'd0);
        wait_rsp(n, d, id);
        chk("div_latency", 64'(n), 64'(8));
        chk("div_data", 64'(d), 64'(14));

        // Response backpressure with a competing request pending
        rsp_ready = 1'b0;
        issue(0, OP_SUB, IRMUX_RS2, 32'd50, 32'd8, 32'd0, 32'd0);
        wait_rsp(n, d, id);
        set_req(1, OP_AND, IRMUX_RS2, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'd0, 32'd0);
        req_valid[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_rsp_valid", 64'(rsp_valid), 64'(1));
            chk("stall_rsp_data", 64'(rsp_data), 64'(42));
            chk("stall_req_ready", 64'(req_ready), 64'(0));
            chk("stall_busy", 64'(busy), 64'(1));
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_release_idle", 64'(busy), 64'(0));
        @(negedge clk);
        chk("stall_then_grant1", 64'(req_ready), 64'(2'b10));
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        wait_rsp(n, d, id);
        chk("and_data", 64'(d), 64'h0F00_0F00);

        // Reset in the middle of a divide
        issue(0, OP_DIV, IRMUX_RS2, 32'd1000, 32'd7, 32'd0, 32'd0);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_alu_op", 64'(alu_op), 64'(0));
        chk("midrst_alu_a", 64'(alu_a), 64'(0));
        set_req(0, OP_ADD, IRMUX_IMMS, 32'd1, 32'd0, 32'd2, 32'd0);
        set_req(1, OP_OR, IRMUX_RS2, 32'd1, 32'd6, 32'd0, 32'd0);
        req_valid = 2'b11;
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_grant0", 64'(req_ready), 64'(2'b01));
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_rsp(n, d, id);
        chk("post_rst_data", 64'(d), 64'(3));
        chk("post_rst_id", 64'(id), 64'(0));

        // Undefined op 1111
        issue(1, 4'b1111, IRMUX_RS2, 32'd123, 32'd456, 32'd0, 32'd0);
        wait_rsp(n, d, id);
        chk("op15_latency", 64'(n), 64'(1));
        chk("op15_data", 64'(d), 64'(0));

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
